// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x4 keypad column scanner, debouncer and one-entry key buffer.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_CYCLES cycles.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic       key_valid,
  output logic [3:0] key_number,
  input  logic       key_ready,
  output logic       overrun
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_SCANS - 1);

  if (SETTLE_CYCLES < 1 || DEBOUNCE_SCANS < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("keypad_scanner: parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [2:0]    r_col;
  logic [2:0]    w_col_nx;
  logic [2:0]    w_rot;
  logic [SW-1:0] r_settle;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] w_cnt_nx;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand_nx;
  logic          r_valid;
  logic [3:0]    r_num;
  logic          r_ovr;
  logic          w_sample;
  logic          w_hit;
  logic          w_match;
  logic          w_zero;
  logic          w_emit;
  logic          w_fire;
  logic [3:0]    w_digit;
  logic [3:0]    w_emit_num;

  assign w_sample = (r_settle == SLAST);
  assign w_zero   = (row == 4'd0);
  assign w_match  = w_hit && (w_digit == r_cand);
  assign w_rot    = {r_col[1:0], r_col[2]};

  // Only single-row hits on a mapped (col,row) pair count as a key.
  always_comb begin
    w_hit   = 1'b0;
    w_digit = 4'd0;
    case ({r_col, row})
      7'b001_0001: begin w_hit = 1'b1; w_digit = 4'd1; end
      7'b010_0001: begin w_hit = 1'b1; w_digit = 4'd2; end
      7'b100_0001: begin w_hit = 1'b1; w_digit = 4'd3; end
      7'b001_0010: begin w_hit = 1'b1; w_digit = 4'd4; end
      7'b010_0010: begin w_hit = 1'b1; w_digit = 4'd5; end
      7'b100_0010: begin w_hit = 1'b1; w_digit = 4'd6; end
      7'b001_0100: begin w_hit = 1'b1; w_digit = 4'd7; end
      7'b010_0100: begin w_hit = 1'b1; w_digit = 4'd8; end
      7'b100_0100: begin w_hit = 1'b1; w_digit = 4'd9; end
      7'b010_1000: begin w_hit = 1'b1; w_digit = 4'd0; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_cnt_nx   = r_cnt;
    w_cand_nx  = r_cand;
    w_emit     = 1'b0;
    w_emit_num = r_cand;
    if (w_sample) begin
      unique case (r_state)
        SCAN: begin
          if (w_hit) begin
            w_cand_nx = w_digit;
            if (DEBOUNCE_SCANS == 1) begin
              w_emit     = 1'b1;
              w_emit_num = w_digit;
              w_cnt_nx   = '0;
              w_state_nx = HELD;
            end else begin
              w_cnt_nx   = DW'(1);
              w_state_nx = DEBOUNCE;
            end
          end else begin
            w_col_nx = w_rot;
          end
        end
        DEBOUNCE: begin
          if (w_match) begin
            if (r_cnt == DLAST) begin
              w_emit     = 1'b1;
              w_cnt_nx   = '0;
              w_state_nx = HELD;
            end else begin
              w_cnt_nx = r_cnt + DW'(1);
            end
          end else begin
            w_cnt_nx   = '0;
            w_col_nx   = w_rot;
            w_state_nx = SCAN;
          end
        end
        HELD: begin
          // r_cnt is reused as the release counter here
          if (w_zero) begin
            if (r_cnt == DLAST) begin
              w_cnt_nx   = '0;
              w_col_nx   = w_rot;
              w_state_nx = SCAN;
            end else begin
              w_cnt_nx = r_cnt + DW'(1);
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        default: begin
          w_cnt_nx   = '0;
          w_state_nx = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SCAN;
      r_col    <= 3'b001;
      r_settle <= '0;
      r_cnt    <= '0;
      r_cand   <= 4'd0;
    end else begin
      r_state  <= w_state_nx;
      r_col    <= w_col_nx;
      r_settle <= w_sample ? '0 : r_settle + SW'(1);
      r_cnt    <= w_cnt_nx;
      r_cand   <= w_cand_nx;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rep;
  logic          r_rep_on;
  logic          w_rep_run;
  logic          w_rep_fire;

  assign w_rep_run  = (r_state == HELD) && (w_state_nx == HELD) &&
                      r_rep_on && !(w_sample && !w_match);
  assign w_rep_fire = w_rep_run && (r_rep == RLAST);
  assign w_fire     = w_emit | w_rep_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep    <= '0;
      r_rep_on <= 1'b0;
    end else if (!w_rep_run) begin
      r_rep    <= '0;
      r_rep_on <= (w_state_nx == HELD) &&
                  ((r_state != HELD) || (w_sample && w_match));
    end else begin
      r_rep <= w_rep_fire ? '0 : r_rep + RW'(1);
    end
  end
`else
  assign w_fire = w_emit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_num   <= 4'd0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_fire) begin
        if (!r_valid || key_ready) begin
          r_valid <= 1'b1;
          r_num   <= w_emit_num;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (key_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign col        = r_col;
  assign key_valid  = r_valid;
  assign key_number = r_num;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad switch-matrix model driving keypad_scanner,
// table vectors, directed corner cases and a randomized press scoreboard.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic [2:0]  col;
  logic        key_valid;
  logic [3:0]  key_number;
  logic        key_ready;
  logic        overrun;
  logic [11:0] keys;

  int checks;
  int errors;
  int ovr_cnt;
  int mon_q[$];
  int exp_q[$];

  typedef struct {
    string       name;
    logic [11:0] keys;
    int          exp_n;
    int          exp_d;
  } vec_t;

  vec_t vecs[14];

  keypad_scanner dut (
    .clk        (clk),
    .reset      (reset),
    .row        (row),
    .col        (col),
    .key_valid  (key_valid),
    .key_number (key_number),
    .key_ready  (key_ready),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // switch matrix: a pressed key connects its column to its row
  always_comb begin
    row = 4'b0;
    for (int c = 0; c < 3; c++)
      if (col[c]) row = row | keys[c*4 +: 4];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (key_valid && key_ready) mon_q.push_back(int'(key_number));
      if (overrun) ovr_cnt++;
    end
  end

  function automatic logic [11:0] kmask(input int d);
    int c;
    int r;
    logic [11:0] m;
    if (d == 0) begin
      c = 1;
      r = 3;
    end else begin
      c = (d - 1) % 3;
      r = (d - 1) / 3;
    end
    m = 12'b1;
    return m << (c * 4 + r);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_q.delete();
    ovr_cnt = 0;
  endtask

  task automatic wait_fresh(input logic [2:0] c);
    logic [2:0] prev;
    bit found;
    prev = col;
    found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      tick(1);
      if (col == c && prev != c) found = 1;
      prev = col;
    end
    check("wait_col", int'(found), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n7;
    int exp_rep;
    logic [2:0] seen;

    checks = 0;
    errors = 0;
    ovr_cnt = 0;
    keys = 12'b0;
    key_ready = 1'b0;
    reset = 1'b1;

    for (int d = 0; d < 10; d++) begin
      vecs[d].name  = $sformatf("digit%0d", d);
      vecs[d].keys  = kmask(d);
      vecs[d].exp_n = 1;
      vecs[d].exp_d = d;
    end
    vecs[10] = '{"a_g",     12'h008, 0, -1};
    vecs[11] = '{"c_g",     12'h800, 0, -1};
    vecs[12] = '{"b_de",    12'h030, 0, -1};
    vecs[13] = '{"c_df",    12'h500, 0, -1};

    // reset state and idle column rotation
    tick(1);
    check("rst_col", int'(col), 1);
    check("rst_valid", int'(key_valid), 0);
    check("rst_number", int'(key_number), 0);
    check("rst_overrun", int'(overrun), 0);
    tick(1);
    reset = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      tick(1);
      check("idle_col", int'(col), 1 << ((j / 4) % 3));
      check("idle_valid", int'(key_valid), 0);
      check("idle_ovr", int'(overrun), 0);
    end

    // key map table
    key_ready = 1'b1;
    foreach (vecs[i]) begin
      clear_mon();
      keys = vecs[i].keys;
      tick(40);
      keys = 12'b0;
      tick(30);
      check({vecs[i].name, "_count"}, mon_q.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0)
        check({vecs[i].name, "_digit"}, (mon_q.size() > 0) ? mon_q[0] : -1,
              vecs[i].exp_d);
      check({vecs[i].name, "_ovr"}, ovr_cnt, 0);
    end

    // single press latency, one pulse, scanning resumes
    clear_mon();
    keys = kmask(5);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (key_valid && lat < 0) lat = i;
    end
    check("lat_seen", int'(lat > 0), 1);
    check("lat_max21", int'(lat <= 21), 1);
    keys = 12'b0;
    tick(20);
    check("b_e_count", mon_q.size(), 1);
    check("b_e_digit", (mon_q.size() > 0) ? mon_q[0] : -1, 5);
    seen = 3'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      seen = seen | col;
    end
    check("resume_scan", int'(seen), 7);

    // bounce on b&g: one matching sample, then release
    clear_mon();
    wait_fresh(3'b010);
    keys = kmask(0);
    tick(4);
    keys = 12'b0;
    tick(20);
    check("bounce_none", mon_q.size(), 0);
    keys = kmask(0);
    tick(40);
    keys = 12'b0;
    tick(30);
    check("bounce_count", mon_q.size(), 1);
    check("bounce_digit", (mon_q.size() > 0) ? mon_q[0] : -1, 0);

    // buffer full: 1 held, 9 dropped
    clear_mon();
    key_ready = 1'b0;
    keys = kmask(1);
    tick(30);
    keys = 12'b0;
    tick(30);
    keys = kmask(9);
    tick(30);
    keys = 12'b0;
    tick(30);
    check("full_valid", int'(key_valid), 1);
    check("full_number", int'(key_number), 1);
    check("full_ovr", ovr_cnt, 1);
    check("full_none", mon_q.size(), 0);
    key_ready = 1'b1;
    tick(1);
    check("drain_valid", int'(key_valid), 0);
    tick(30);
    check("drain_count", mon_q.size(), 1);
    check("drain_digit", (mon_q.size() > 0) ? mon_q[0] : -1, 1);

    // reset while debouncing 3
    clear_mon();
    keys = kmask(3);
    wait_fresh(3'b100);
    tick(6);
    reset = 1'b1;
    tick(1);
    check("mid_rst_col", int'(col), 1);
    check("mid_rst_valid", int'(key_valid), 0);
    reset = 1'b0;
    keys = 12'b0;
    tick(40);
    check("mid_rst_none", mon_q.size(), 0);

    // long hold of 7
`ifdef KEYPAD_REPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    clear_mon();
    keys = kmask(7);
    tick(220);
    keys = 12'b0;
    tick(30);
    n7 = 0;
    foreach (mon_q[i]) if (mon_q[i] == 7) n7++;
    check("hold7_count", mon_q.size(), exp_rep);
    check("hold7_digit", n7, exp_rep);

    // random presses with a random consumer
    clear_mon();
    exp_q.delete();
    for (int p = 0; p < 12; p++) begin
      int d;
      int h;
      d = $urandom_range(0, 9);
      exp_q.push_back(d);
      keys = kmask(d);
      h = $urandom_range(25, 60);
      for (int i = 0; i < h; i++) begin
        key_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
      keys = 12'b0;
      h = $urandom_range(25, 60);
      for (int i = 0; i < h; i++) begin
        key_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    key_ready = 1'b1;
    tick(10);
    check("rand_count", mon_q.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("rand_key%0d", i), (i < mon_q.size()) ? mon_q[i] : -1,
            exp_q[i]);
    check("rand_ovr", ovr_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
